cpu_control: RTL and testbench

- Multicycle control FSM for the RV32I datapath.
- Sequences fetch, decode, execute, memory and writeback by driving every datapath load and mux-select signal.
- Runs the memory read/write handshake.
- Sits beside the datapath inside the cpu top level. It consumes opcode/funct3/funct7/br_en and mem_resp.

---
 rtl/cpu_control_pkg.sv | 116 +++++++++++
 rtl/cpu_control.sv | 249 ++++++++++++++++++++++++
 tb/tb_cpu_control.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_control_pkg.sv
// ----------------------------------------------------------------------------
// cpu_control_pkg
// Shared RV32I type definitions for the multicycle CPU: opcode and funct3
// encodings, ALU operations, the control FSM state type and the datapath
// mux-select constants driven by cpu_control.
// No ports (package).
// ----------------------------------------------------------------------------
package cpu_control_pkg;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    beq  = 3'b000,
    bne  = 3'b001,
    blt  = 3'b100,
    bge  = 3'b101,
    bltu = 3'b110,
    bgeu = 3'b111
  } branch_funct3_t;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  typedef enum logic [2:0] {
    add  = 3'b000,
    sll  = 3'b001,
    slt  = 3'b010,
    sltu = 3'b011,
    axor = 3'b100,
    sr   = 3'b101,
    aor  = 3'b110,
    aand = 3'b111
  } arith_funct3_t;

  typedef enum logic [2:0] {
    alu_add = 3'b000,
    alu_sll = 3'b001,
    alu_sra = 3'b010,
    alu_sub = 3'b011,
    alu_xor = 3'b100,
    alu_srl = 3'b101,
    alu_or  = 3'b110,
    alu_and = 3'b111
  } alu_ops;

  typedef enum logic [3:0] {
    S_FETCH1    = 4'd0,
    S_FETCH2    = 4'd1,
    S_FETCH3    = 4'd2,
    S_DECODE    = 4'd3,
    S_IMM       = 4'd4,
    S_REG       = 4'd5,
    S_LUI       = 4'd6,
    S_AUIPC     = 4'd7,
    S_BR        = 4'd8,
    S_CALC_ADDR = 4'd9,
    S_LD1       = 4'd10,
    S_LD2       = 4'd11,
    S_ST1       = 4'd12,
    S_ILLEGAL   = 4'd13,
    S_HALT      = 4'd14
  } ctrl_state_t;

  localparam logic       pcmux_pc_plus4   = 1'b0;
  localparam logic       pcmux_alu        = 1'b1;

  localparam logic       cmpmux_rs2       = 1'b0;
  localparam logic       cmpmux_i         = 1'b1;

  localparam logic       alumux1_rs1      = 1'b0;
  localparam logic       alumux1_pc       = 1'b1;

  localparam logic [2:0] alumux2_i        = 3'd0;
  localparam logic [2:0] alumux2_u        = 3'd1;
  localparam logic [2:0] alumux2_b        = 3'd2;
  localparam logic [2:0] alumux2_s        = 3'd3;
  localparam logic [2:0] alumux2_rs2      = 3'd4;

  localparam logic       marmux_pc        = 1'b0;
  localparam logic       marmux_alu       = 1'b1;

  localparam logic [1:0] regfilemux_alu   = 2'd0;
  localparam logic [1:0] regfilemux_br_en = 2'd1;
  localparam logic [1:0] regfilemux_u_imm = 2'd2;
  localparam logic [1:0] regfilemux_mdr   = 2'd3;

  localparam logic [3:0] byte_en_word     = 4'b1111;

  // Only full-word memory accesses are implemented by the datapath.
  function automatic logic is_word_access(input logic [2:0] f3);
    return f3 == 3'b010;
  endfunction

endpackage

// File: rtl/cpu_control.sv
// ----------------------------------------------------------------------------
// cpu_control
// Multicycle control FSM for the RV32I datapath. Steps each instruction
// through fetch, decode, execute, memory and writeback, drives every datapath
// register load and mux select, and runs the memory read/write handshake.
//
// Ports:
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   opcode/funct3/funct7 instruction fields from IR
//   br_en               comparator result
//   mem_resp            memory done, single-cycle pulse
//   load_*              datapath register loads
//   *mux_sel            datapath mux selects
//   aluop, cmpop        ALU / comparator operation
//   mem_read/mem_write  memory strobes, mem_byte_enable write mask
//   illegal             unsupported-instruction flag
//
// Build option:
//   CPU_CONTROL_HALT_EN  when defined, an illegal instruction parks the FSM
//                        in HALT (illegal held high) until reset; otherwise
//                        the instruction is skipped.
//
// state     | meaning
// ----------+---------------------------------------------------------
// FETCH1    | MAR <= PC
// FETCH2    | memory read of instruction, wait for mem_resp
// FETCH3    | IR <= MDR
// DECODE    | branch on opcode
// IMM/REG   | ALU op with immediate / rs2, writeback, PC += 4
// LUI       | rd <= u_imm, PC += 4
// AUIPC     | rd <= PC + u_imm, PC += 4
// BR        | PC <= br_en ? PC + b_imm : PC + 4
// CALC_ADDR | MAR <= rs1 + imm (store also latches data_out)
// LD1       | memory read, wait for mem_resp
// LD2       | rd <= MDR, PC += 4
// ST1       | memory write, wait for mem_resp, PC += 4 on resp
// ILLEGAL   | flag illegal, skip instruction
// HALT      | parked with illegal high until reset
// ----------------------------------------------------------------------------
module cpu_control
  import cpu_control_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic [6:0]     opcode,
  input  logic [2:0]     funct3,
  input  logic [6:0]     funct7,
  input  logic           br_en,
  input  logic           mem_resp,
  output logic           load_pc,
  output logic           load_ir,
  output logic           load_regfile,
  output logic           load_mar,
  output logic           load_mdr,
  output logic           load_data_out,
  output logic           pcmux_sel,
  output logic           cmpmux_sel,
  output logic           alumux1_sel,
  output logic           marmux_sel,
  output logic [2:0]     alumux2_sel,
  output logic [1:0]     regfilemux_sel,
  output alu_ops         aluop,
  output branch_funct3_t cmpop,
  output logic           mem_read,
  output logic           mem_write,
  output logic [3:0]     mem_byte_enable,
  output logic           illegal
);

  ctrl_state_t state_q, state_d;

  logic is_imm_state;
  logic is_store;
  logic alt_op;

  assign is_imm_state = (state_q == S_IMM);
  assign is_store     = (opcode == op_store);
  // funct7[5] selects sra over srl and sub over add; other funct7 bits are
  // not decoded by this controller.
  assign alt_op       = funct7[5];

  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH1;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH1: state_d = S_FETCH2;
      S_FETCH2: if (mem_resp) state_d = S_FETCH3;
      S_FETCH3: state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          op_imm:            state_d = S_IMM;
          op_reg:            state_d = S_REG;
          op_lui:            state_d = S_LUI;
          op_auipc:          state_d = S_AUIPC;
          op_br:             state_d = S_BR;
          op_load, op_store: state_d = S_CALC_ADDR;
          default:           state_d = S_ILLEGAL;
        endcase
      end
      S_IMM, S_REG, S_LUI, S_AUIPC, S_BR, S_LD2: state_d = S_FETCH1;
      S_CALC_ADDR: begin
        if (!is_word_access(funct3)) begin
          state_d = S_ILLEGAL;
        end else if (is_store) begin
          state_d = S_ST1;
        end else begin
          state_d = S_LD1;
        end
      end
      S_LD1: if (mem_resp) state_d = S_LD2;
      S_ST1: if (mem_resp) state_d = S_FETCH1;
`ifdef CPU_CONTROL_HALT_EN
      S_ILLEGAL: state_d = S_HALT;
      S_HALT:    state_d = S_HALT;
`else
      S_ILLEGAL: state_d = S_FETCH1;
      // Unreachable without the halt option; recover to fetch.
      S_HALT:    state_d = S_FETCH1;
`endif
      default:   state_d = S_FETCH1;
    endcase
  end

  // --------------------------------------------------------------------------
  // State actions
  // --------------------------------------------------------------------------
  always_comb begin
    load_pc         = 1'b0;
    load_ir         = 1'b0;
    load_regfile    = 1'b0;
    load_mar        = 1'b0;
    load_mdr        = 1'b0;
    load_data_out   = 1'b0;
    pcmux_sel       = pcmux_pc_plus4;
    cmpmux_sel      = cmpmux_rs2;
    alumux1_sel     = alumux1_rs1;
    marmux_sel      = marmux_pc;
    alumux2_sel     = alumux2_i;
    regfilemux_sel  = regfilemux_alu;
    aluop           = alu_add;
    cmpop           = branch_funct3_t'(funct3);
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = byte_en_word;
    illegal         = 1'b0;

    case (state_q)
      S_FETCH1: begin
        load_mar   = 1'b1;
        marmux_sel = marmux_pc;
      end
      S_FETCH2: begin
        mem_read = 1'b1;
        load_mdr = 1'b1;
      end
      S_FETCH3: load_ir = 1'b1;
      S_IMM, S_REG: begin
        load_regfile = 1'b1;
        load_pc      = 1'b1;
        pcmux_sel    = pcmux_pc_plus4;
        alumux2_sel  = is_imm_state ? alumux2_i : alumux2_rs2;
        // arith funct3 and alu_ops share encodings except for the cases below
        aluop        = alu_ops'(funct3);
        case (funct3)
          sr:  if (alt_op) aluop = alu_sra;
          add: if (!is_imm_state && alt_op) aluop = alu_sub;
          slt: begin
            regfilemux_sel = regfilemux_br_en;
            cmpop          = blt;
            cmpmux_sel     = is_imm_state ? cmpmux_i : cmpmux_rs2;
          end
          sltu: begin
            regfilemux_sel = regfilemux_br_en;
            cmpop          = bltu;
            cmpmux_sel     = is_imm_state ? cmpmux_i : cmpmux_rs2;
          end
          default: ;
        endcase
      end
      S_LUI: begin
        regfilemux_sel = regfilemux_u_imm;
        load_regfile   = 1'b1;
        load_pc        = 1'b1;
      end
      S_AUIPC: begin
        alumux1_sel  = alumux1_pc;
        alumux2_sel  = alumux2_u;
        aluop        = alu_add;
        load_regfile = 1'b1;
        load_pc      = 1'b1;
      end
      S_BR: begin
        alumux1_sel = alumux1_pc;
        alumux2_sel = alumux2_b;
        aluop       = alu_add;
        pcmux_sel   = br_en ? pcmux_alu : pcmux_pc_plus4;
        load_pc     = 1'b1;
      end
      S_CALC_ADDR: begin
        marmux_sel = marmux_alu;
        load_mar   = 1'b1;
        aluop      = alu_add;
        if (is_store) begin
          alumux2_sel   = alumux2_s;
          load_data_out = 1'b1;
        end else begin
          alumux2_sel   = alumux2_i;
        end
      end
      S_LD1: begin
        mem_read = 1'b1;
        load_mdr = 1'b1;
      end
      S_LD2: begin
        regfilemux_sel = regfilemux_mdr;
        load_regfile   = 1'b1;
        load_pc        = 1'b1;
      end
      S_ST1: begin
        mem_write = 1'b1;
        // PC advances in the same cycle the write completes.
        if (mem_resp) load_pc = 1'b1;
      end
      S_ILLEGAL: begin
        load_pc = 1'b1;
        illegal = 1'b1;
      end
      S_HALT: illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_control.sv
// ----------------------------------------------------------------------------
// tb_cpu_control
// Directed bench for cpu_control. For each instruction the expected per-cycle
// control vector (plus the mem_resp/rst_n/br_en to drive in that cycle) is
// pushed onto a scoreboard queue from a small reference model, then the queue
// is drained one clock at a time and compared against the DUT outputs.
// Honours CPU_CONTROL_HALT_EN for the illegal-instruction case.
// ----------------------------------------------------------------------------
module tb_cpu_control;
  import cpu_control_pkg::*;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [6:0]     opcode;
  logic [2:0]     funct3;
  logic [6:0]     funct7;
  logic           br_en;
  logic           mem_resp;
  logic           load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out;
  logic           pcmux_sel, cmpmux_sel, alumux1_sel, marmux_sel;
  logic [2:0]     alumux2_sel;
  logic [1:0]     regfilemux_sel;
  alu_ops         aluop;
  branch_funct3_t cmpop;
  logic           mem_read, mem_write;
  logic [3:0]     mem_byte_enable;
  logic           illegal;

  cpu_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .br_en(br_en), .mem_resp(mem_resp),
    .load_pc(load_pc), .load_ir(load_ir), .load_regfile(load_regfile),
    .load_mar(load_mar), .load_mdr(load_mdr), .load_data_out(load_data_out),
    .pcmux_sel(pcmux_sel), .cmpmux_sel(cmpmux_sel), .alumux1_sel(alumux1_sel),
    .marmux_sel(marmux_sel), .alumux2_sel(alumux2_sel),
    .regfilemux_sel(regfilemux_sel), .aluop(aluop), .cmpop(cmpop),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out;
    logic       pcmux_sel, cmpmux_sel, alumux1_sel, marmux_sel;
    logic [2:0] alumux2_sel;
    logic [1:0] regfilemux_sel;
    logic [2:0] aluop;
    logic [2:0] cmpop;
    logic       mem_read, mem_write;
    logic [3:0] mem_byte_enable;
    logic       illegal;
  } ctl_t;

  typedef struct {
    ctl_t exp;
    logic resp;
    logic rst;
    logic br;
  } step_t;

  step_t sb_q[$];
  string tag_q[$];
  int    checks = 0;
  int    failures = 0;

  function automatic ctl_t observe();
    ctl_t o;
    o.load_pc = load_pc;           o.load_ir = load_ir;
    o.load_regfile = load_regfile; o.load_mar = load_mar;
    o.load_mdr = load_mdr;         o.load_data_out = load_data_out;
    o.pcmux_sel = pcmux_sel;       o.cmpmux_sel = cmpmux_sel;
    o.alumux1_sel = alumux1_sel;   o.marmux_sel = marmux_sel;
    o.alumux2_sel = alumux2_sel;   o.regfilemux_sel = regfilemux_sel;
    o.aluop = aluop;               o.cmpop = cmpop;
    o.mem_read = mem_read;         o.mem_write = mem_write;
    o.mem_byte_enable = mem_byte_enable;
    o.illegal = illegal;
    return o;
  endfunction

  function automatic ctl_t dflt(input logic [2:0] f3);
    ctl_t c;
    c = '0;
    c.cmpop = f3;
    c.mem_byte_enable = 4'hF;
    return c;
  endfunction

  task automatic push(input ctl_t e, input logic resp, input logic rst,
                      input logic br, input string tag);
    step_t s;
    s.exp = e; s.resp = resp; s.rst = rst; s.br = br;
    sb_q.push_back(s);
    tag_q.push_back(tag);
  endtask

  // Drain the scoreboard: drive the cycle's inputs, sample mid-cycle, compare.
  task automatic run_q();
    step_t s;
    string t;
    ctl_t  obs;
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      t = tag_q.pop_front();
      mem_resp = s.resp;
      rst_n    = s.rst;
      br_en    = s.br;
      @(negedge clk);
      obs = observe();
      checks++;
      assert (obs === s.exp) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", t, obs, s.exp);
      end
      @(posedge clk);
      #1;
    end
    mem_resp = 1'b0;
    rst_n    = 1'b1;
  endtask

  // Reference model: expected cycle sequence for one instruction.
  // fd/md = cycles of memory wait before mem_resp in fetch / data access.
  // stray = pulse mem_resp in FETCH3 and DECODE, where it must be ignored.
  task automatic model_instr(input logic [31:0] w, input logic br, input int fd,
                             input int md, input logic stray, input string name);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    ctl_t       d, e;
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    opcode = op; funct3 = f3; funct7 = f7;
    d = dflt(f3);

    e = d; e.load_mar = 1'b1;
    push(e, 1'b0, 1'b1, br, {name, ":fetch1"});
    for (int i = 0; i <= fd; i++) begin
      e = d; e.mem_read = 1'b1; e.load_mdr = 1'b1;
      push(e, (i == fd), 1'b1, br, {name, ":fetch2"});
    end
    e = d; e.load_ir = 1'b1;
    push(e, stray, 1'b1, br, {name, ":fetch3"});
    push(d, stray, 1'b1, br, {name, ":decode"});

    e = d;
    case (op)
      7'b0010011, 7'b0110011: begin
        e.load_regfile = 1'b1;
        e.load_pc = 1'b1;
        e.alumux2_sel = (op == 7'b0010011) ? 3'd0 : 3'd4;
        e.aluop = f3;
        if (f3 == 3'b101 && f7[5]) e.aluop = 3'b010;
        if (op == 7'b0110011 && f3 == 3'b000 && f7[5]) e.aluop = 3'b011;
        if (f3 == 3'b010 || f3 == 3'b011) begin
          e.regfilemux_sel = 2'd1;
          e.cmpop = (f3 == 3'b010) ? 3'b100 : 3'b110;
          e.cmpmux_sel = (op == 7'b0010011);
        end
        push(e, 1'b0, 1'b1, br, {name, ":alu"});
      end
      7'b0110111: begin
        e.regfilemux_sel = 2'd2; e.load_regfile = 1'b1; e.load_pc = 1'b1;
        push(e, 1'b0, 1'b1, br, {name, ":lui"});
      end
      7'b0010111: begin
        e.alumux1_sel = 1'b1; e.alumux2_sel = 3'd1;
        e.load_regfile = 1'b1; e.load_pc = 1'b1;
        push(e, 1'b0, 1'b1, br, {name, ":auipc"});
      end
      7'b1100011: begin
        e.alumux1_sel = 1'b1; e.alumux2_sel = 3'd2;
        e.pcmux_sel = br; e.load_pc = 1'b1;
        push(e, 1'b0, 1'b1, br, {name, ":br"});
      end
      7'b0000011, 7'b0100011: begin
        e.marmux_sel = 1'b1; e.load_mar = 1'b1;
        e.alumux2_sel = (op == 7'b0100011) ? 3'd3 : 3'd0;
        e.load_data_out = (op == 7'b0100011);
        push(e, 1'b0, 1'b1, br, {name, ":calc_addr"});
        if (f3 != 3'b010) begin
          e = d; e.load_pc = 1'b1; e.illegal = 1'b1;
          push(e, 1'b0, 1'b1, br, {name, ":illegal"});
        end else if (op == 7'b0000011) begin
          for (int i = 0; i <= md; i++) begin
            e = d; e.mem_read = 1'b1; e.load_mdr = 1'b1;
            push(e, (i == md), 1'b1, br, {name, ":ld1"});
          end
          e = d; e.regfilemux_sel = 2'd3; e.load_regfile = 1'b1; e.load_pc = 1'b1;
          push(e, 1'b0, 1'b1, br, {name, ":ld2"});
        end else begin
          for (int i = 0; i <= md; i++) begin
            e = d; e.mem_write = 1'b1; e.load_pc = (i == md);
            push(e, (i == md), 1'b1, br, {name, ":st1"});
          end
        end
      end
      default: begin
        e.load_pc = 1'b1; e.illegal = 1'b1;
        push(e, 1'b0, 1'b1, br, {name, ":illegal"});
      end
    endcase
  endtask

  initial begin
    ctl_t d0, e;
    rst_n = 1'b0; opcode = '0; funct3 = '0; funct7 = '0;
    br_en = 1'b0; mem_resp = 1'b0;
    @(posedge clk);
    #1;

    // Reset state: FETCH1 while reset is still held.
    d0 = dflt(3'b000);
    e = d0; e.load_mar = 1'b1;
    push(e, 1'b0, 1'b0, 1'b0, "reset:fetch1");
    run_q();

    model_instr(32'h00500093, 1'b0, 0, 0, 1'b1, "addi");
    run_q();

    // Reset mid-FETCH2 with mem_read high, held for two edges.
    opcode = 7'h13; funct3 = 3'b000; funct7 = '0;
    e = d0; e.load_mar = 1'b1;
    push(e, 1'b0, 1'b1, 1'b0, "rstmid:fetch1");
    e = d0; e.mem_read = 1'b1; e.load_mdr = 1'b1;
    push(e, 1'b0, 1'b1, 1'b0, "rstmid:fetch2");
    push(e, 1'b0, 1'b0, 1'b0, "rstmid:fetch2_rst");
    e = d0; e.load_mar = 1'b1;
    push(e, 1'b0, 1'b0, 1'b0, "rstmid:fetch1_rst");
    run_q();
    // Released: this cycle is FETCH1 again, covered by the next fetch.

    model_instr(32'h402081B3, 1'b0, 0, 0, 1'b0, "sub");      run_q();
    model_instr(32'h0070B293, 1'b0, 1, 0, 1'b0, "sltiu");    run_q();
    model_instr(32'h0020A3B3, 1'b0, 0, 0, 1'b0, "slt");      run_q();
    model_instr(32'h4020D313, 1'b0, 0, 0, 1'b0, "srai");     run_q();
    model_instr(32'h123450B7, 1'b0, 0, 0, 1'b0, "lui");      run_q();
    model_instr(32'h00001117, 1'b0, 0, 0, 1'b0, "auipc");    run_q();
    model_instr(32'h00208463, 1'b1, 0, 0, 1'b0, "beq_t");    run_q();
    model_instr(32'h00208463, 1'b0, 2, 0, 1'b0, "beq_nt");   run_q();
    model_instr(32'h0000A203, 1'b0, 1, 3, 1'b0, "lw");       run_q();
    model_instr(32'h0020A223, 1'b0, 0, 2, 1'b0, "sw");       run_q();
    model_instr(32'h0000A223 | 32'h0020_0000, 1'b0, 0, 0, 1'b0, "sw_fast"); run_q();
    model_instr(32'h00008203, 1'b0, 0, 0, 1'b0, "lb");
`ifdef CPU_CONTROL_HALT_EN
    e = dflt(3'b000); e.illegal = 1'b1;
    push(e, 1'b0, 1'b1, 1'b0, "lb:halt");
    push(e, 1'b0, 1'b0, 1'b0, "lb:halt_rst");
`endif
    run_q();

    model_instr(32'h0000006F, 1'b0, 0, 0, 1'b0, "jal");
`ifdef CPU_CONTROL_HALT_EN
    e = dflt(3'b000); e.illegal = 1'b1;
    push(e, 1'b1, 1'b1, 1'b0, "jal:halt0");
    push(e, 1'b0, 1'b1, 1'b0, "jal:halt1");
    push(e, 1'b0, 1'b1, 1'b0, "jal:halt2");
    push(e, 1'b0, 1'b0, 1'b0, "jal:halt_rst");
`endif
    run_q();

    // Next instruction must start cleanly from FETCH1.
    model_instr(32'h00500093, 1'b0, 0, 0, 1'b0, "addi_after");
    run_q();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
